gobou_serializer: RTL
=====================

Name: gobou_serializer

Overview:
- Downstream stage of the gobou FC control core.
- On each serial_we pulse it captures the GOBOU_CORE parallel neuron results from the gobou cores and emits them one per cycle as the signed write_result stream, which the control core writes to image memory.
- Holds two banks, so the next output group can be captured while the current one drains.
- Also applies optional ReLU, trims the last partial group, and flags overrun.

Parameters:
- DWIDTH, 16, data word width (signed).
- GOBOU_CORE, 16, number of parallel cores, i.e. lanes per group.
- CNTW, 5, width of lane count; must be at least clog2(GOBOU_CORE)+1.

Ports:
- clk  in  1  clock
- xrst  in  1  reset, asynchronous, active-high
- serial_we  in  1  load strobe for one group (single-cycle pulse)
- in_data  in  GOBOU_CORE*DWIDTH  packed core results; lane i is bits [i*DWIDTH +: DWIDTH]
- valid_num  in  CNTW  valid lanes in this group, sampled with serial_we
- relu_en  in  1  apply ReLU to this group, sampled with serial_we
- clr_overrun  in  1  clears the sticky overrun flag
- out_valid  out  1  write_result holds a valid element this cycle
- write_result  out  DWIDTH  signed output element
- out_last  out  1  high with the final element of a group
- busy  out  1  at least one bank is occupied
- overrun  out  1  sticky: a load was dropped

Behaviour:
- Reset values (async, xrst=1): out_valid=0, write_result=0, out_last=0, busy=0, overrun=0. Both banks are empty, rd_bank=0, lane counter=0, FSM=S_IDLE. Reset mid-drain discards everything immediately with no partial output.
- Load acceptance:
  - A pulse with valid_num=0 is ignored and has no other effect.
  - valid_num greater than GOBOU_CORE is clamped to GOBOU_CORE.
  - At capture, each lane is stored as its raw value, or as max(x,0) when relu_en=1. Lanes at index valid_num or above are stored but never emitted.
- Bank allocation:
  - Both banks empty: load goes to rd_bank.
  - One bank occupied: load goes to the other bank, which becomes pending.
  - Both occupied: load is dropped and overrun is set.
  - Exception: a load arriving in the same cycle the draining bank emits its last element is accepted, because that bank frees at the same edge.
- FSM:
  - S_IDLE: if the load is accepted, go to S_EMIT with lane=0.
  - S_EMIT: register outputs from lane `lane` of rd_bank; lane increments each cycle.
  - When lane == num-1: assert out_last, free rd_bank, toggle rd_bank. If the other bank is occupied (or loaded this cycle), stay in S_EMIT with lane=0; otherwise go to S_IDLE.
- Latency: the first element is registered at the edge after serial_we, so out_valid rises 1 cycle after the pulse. A group of n lanes gives n consecutive out_valid cycles.
- Back-to-back groups: no bubble between the last element of one group and the first of the pending group.
- Outputs when out_valid=0: write_result holds 0 and out_last=0.
- busy is high when either bank is occupied; it drops on the edge that emits the last element of the last group.
- overrun is sticky until clr_overrun. If a drop and clr_overrun occur in the same cycle, the drop wins and overrun=1.
- Arithmetic: no rescaling or saturation; data passes through width-preserving. ReLU compares against signed zero.

Decomposition:
- Shared gobou header: DWIDTH, GOBOU_CORE, CNTW, and FSM state encodings S_IDLE=0, S_EMIT=1.
- One natural sub-module: gobou_serial_bank. It holds one bank: a register array, an occupied flag, a stored count, and capture-with-ReLU logic. It is instantiated twice.
- The top level holds the FSM, rd_bank, lane counter, and overrun.

Test Plan:
- Single group, full: GOBOU_CORE=16, valid_num=16, relu_en=0, lane i = i-8 → out_valid for 16 cycles starting 1 cycle after the pulse; values -8..7 in order; out_last only with 7; busy then 0.
- ReLU and partial group: valid_num=5, relu_en=1, lanes {-3,4,-1,0,9,...} → emits 0,4,0,0,9; out_last on 9; lanes 5..15 never appear.
- Back-to-back: load A (16 lanes); load B 3 cycles later → 16 A elements then B lane 0 on the very next cycle, no gap; out_last pulses twice.
- Overrun and race: load A, B, then C while A is mid-drain → C dropped, overrun=1 and stays high. Load C on A's last-element cycle → accepted, no overrun. clr_overrun → overrun=0.
- Edge inputs: valid_num=0 → no output, busy stays 0. valid_num=20 → exactly 16 elements emitted.
- Reset mid-drain: assert xrst at element 6 → out_valid, busy, and out_last drop to 0 without waiting for a clock edge. After release a fresh load emits from lane 0 with normal latency.

Source files
------------

// File: rtl/gobou_serializer_pkg.sv
// Shared gobou serializer definitions.
// Purpose: word/lane geometry, FSM state encoding and the ReLU helper used
// both at bank capture and on the idle-cycle bypass path.
// No ports (package).
package gobou_serializer_pkg;

  localparam int DWIDTH     = 16;  // signed data word width
  localparam int GOBOU_CORE = 16;  // parallel cores = lanes per group
  localparam int CNTW       = 5;   // lane-count width, >= clog2(GOBOU_CORE)+1
  localparam int LANEW      = $clog2(GOBOU_CORE);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  // Signed comparison against zero; width preserving, no saturation.
  function automatic logic signed [DWIDTH-1:0] relu(
    input logic signed [DWIDTH-1:0] x,
    input logic                     en
  );
    return (en && (x < 0)) ? '0 : x;
  endfunction

endpackage

// File: rtl/gobou_serializer_if.sv
// Bus between the gobou control core and the serializer.
// Purpose: bundles the load strobe, packed core results and the serial
// output stream.
// Signals: serial_we, in_data, valid_num, relu_en, clr_overrun (control core
// -> serializer); out_valid, write_result, out_last, busy, overrun
// (serializer -> control core).
//
// Handshake: there is no ready. serial_we is a single-cycle strobe; in_data,
// valid_num and relu_en are sampled on the edge where serial_we=1. A load that
// finds no free bank is dropped and reported through the sticky overrun flag.
// out_valid qualifies write_result/out_last for exactly one cycle per element;
// the consumer must take every element offered.
interface gobou_serializer_if;
  import gobou_serializer_pkg::*;

  logic                         serial_we;
  logic [GOBOU_CORE*DWIDTH-1:0] in_data;
  logic [CNTW-1:0]              valid_num;
  logic                         relu_en;
  logic                         clr_overrun;
  logic                         out_valid;
  logic signed [DWIDTH-1:0]     write_result;
  logic                         out_last;
  logic                         busy;
  logic                         overrun;

  modport master (
    output serial_we, in_data, valid_num, relu_en, clr_overrun,
    input  out_valid, write_result, out_last, busy, overrun
  );

  modport slave (
    input  serial_we, in_data, valid_num, relu_en, clr_overrun,
    output out_valid, write_result, out_last, busy, overrun
  );

endinterface

// File: rtl/gobou_serial_bank.sv
// One capture bank of the serializer.
// Purpose: stores a full group of lanes (ReLU applied at capture), the number
// of lanes to emit, and an occupied flag.
// Ports: clk, xrst (async active-high); load_i/relu_en_i/num_i/data_i capture
// a group; free_i clears occupancy; rd_lane_i selects rd_data_o;
// occupied_o, num_o report bank status.
module gobou_serial_bank
  import gobou_serializer_pkg::*;
(
  input  logic                         clk,
  input  logic                         xrst,
  input  logic                         load_i,
  input  logic                         relu_en_i,
  input  logic [CNTW-1:0]              num_i,
  input  logic [GOBOU_CORE*DWIDTH-1:0] data_i,
  input  logic                         free_i,
  input  logic [LANEW-1:0]             rd_lane_i,
  output logic                         occupied_o,
  output logic [CNTW-1:0]              num_o,
  output logic signed [DWIDTH-1:0]     rd_data_o
);

  logic signed [DWIDTH-1:0] mem_q [GOBOU_CORE];
  logic                     occ_q;
  logic [CNTW-1:0]          num_q;

  // A load in the same cycle as a free wins: the bank is being recycled by
  // the group that arrives as the previous one leaves.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      occ_q <= 1'b0;
      num_q <= '0;
      for (int i = 0; i < GOBOU_CORE; i++) mem_q[i] <= '0;
    end else if (load_i) begin
      occ_q <= 1'b1;
      num_q <= num_i;
      for (int i = 0; i < GOBOU_CORE; i++)
        mem_q[i] <= relu(data_i[i*DWIDTH +: DWIDTH], relu_en_i);
    end else if (free_i) begin
      occ_q <= 1'b0;
    end
  end

  assign occupied_o = occ_q;
  assign num_o      = num_q;
  assign rd_data_o  = mem_q[rd_lane_i];

endmodule

// File: rtl/gobou_serializer.sv
// gobou serializer top.
// Purpose: captures a group of GOBOU_CORE parallel results on serial_we and
// streams the valid lanes out one per cycle, double-banked so a second group
// can wait while the first drains.
// Ports: clk, xrst (async active-high); bus (slave modport of
// gobou_serializer_if); dbg_state_o exposes the FSM state.
module gobou_serializer
  import gobou_serializer_pkg::*;
(
  input  logic                clk,
  input  logic                xrst,
  gobou_serializer_if.slave   bus,
  output state_e              dbg_state_o
);

  state_e                   state_q, state_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [LANEW-1:0]         lane_q, lane_d;
  logic                     overrun_q, overrun_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic signed [DWIDTH-1:0] wr_q, wr_d;

  logic [1:0]               occ, load_en, free_en;
  logic [CNTW-1:0]          bank_num  [2];
  logic signed [DWIDTH-1:0] bank_data [2];
  logic [CNTW-1:0]          num_clamp, cur_num;
  logic signed [DWIDTH-1:0] cur_data;
  logic                     load_req, accept, drop, tgt, bank_last;

  gobou_serial_bank u_bank0 (
    .clk(clk), .xrst(xrst), .load_i(load_en[0]), .relu_en_i(bus.relu_en),
    .num_i(num_clamp), .data_i(bus.in_data), .free_i(free_en[0]),
    .rd_lane_i(lane_q), .occupied_o(occ[0]), .num_o(bank_num[0]),
    .rd_data_o(bank_data[0])
  );

  gobou_serial_bank u_bank1 (
    .clk(clk), .xrst(xrst), .load_i(load_en[1]), .relu_en_i(bus.relu_en),
    .num_i(num_clamp), .data_i(bus.in_data), .free_i(free_en[1]),
    .rd_lane_i(lane_q), .occupied_o(occ[1]), .num_o(bank_num[1]),
    .rd_data_o(bank_data[1])
  );

  assign num_clamp = (bus.valid_num > CNTW'(GOBOU_CORE)) ? CNTW'(GOBOU_CORE) : bus.valid_num;
  assign load_req  = bus.serial_we && (bus.valid_num != '0);
  assign cur_num   = bank_num[rd_bank_q];
  assign cur_data  = bank_data[rd_bank_q];
  assign bank_last = (state_q == S_EMIT) && (CNTW'(lane_q) == cur_num - CNTW'(1));

  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    lane_d      = lane_q;
    overrun_d   = overrun_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    wr_d        = '0;
    load_en     = '0;
    free_en     = '0;
    accept      = 1'b0;
    drop        = 1'b0;
    tgt         = rd_bank_q;

    // Bank allocation. With one bank busy it is always rd_bank, so the free
    // one is simply the bank whose occupied bit is clear (tgt = occ[0]).
    if (load_req) begin
      if (occ == 2'b00) begin
        accept = 1'b1;
        tgt    = rd_bank_q;
      end else if (occ != 2'b11) begin
        accept = 1'b1;
        tgt    = occ[0];
      end else if (bank_last) begin
        accept = 1'b1;
        tgt    = rd_bank_q;
      end else begin
        drop = 1'b1;
      end
    end

    if (drop)                 overrun_d = 1'b1;
    else if (bus.clr_overrun) overrun_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Lane 0 bypasses the bank so the first element is registered on the
        // capture edge itself. A one-lane group never needs a bank at all.
        if (accept) begin
          out_valid_d = 1'b1;
          wr_d        = relu(bus.in_data[DWIDTH-1:0], bus.relu_en);
          if (num_clamp == CNTW'(1)) begin
            out_last_d = 1'b1;
          end else begin
            load_en[tgt] = 1'b1;
            lane_d       = LANEW'(1);
            state_d      = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        out_valid_d = 1'b1;
        wr_d        = cur_data;
        if (accept) load_en[tgt] = 1'b1;
        if (bank_last) begin
          out_last_d         = 1'b1;
          free_en[rd_bank_q] = 1'b1;
          rd_bank_d          = !rd_bank_q;
          lane_d             = '0;
          if (!(occ[!rd_bank_q] || accept)) state_d = S_IDLE;
        end else begin
          lane_d = lane_q + LANEW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      lane_q      <= '0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      wr_q        <= '0;
    end else begin
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      lane_q      <= lane_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      wr_q        <= wr_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign bus.write_result = wr_q;
  assign bus.busy         = |occ;
  assign bus.overrun      = overrun_q;
  assign dbg_state_o      = state_q;

endmodule
